seg_scan_mux: RTL

//  Time-multiplexed 7-segment display driver, downstream of the clock/counter +
//  bcd_to_seg_mod stages. It takes the already-encoded segment bytes of every

---
 rtl/seg_scan_mux.sv | 121 ++++++++++++
 1 files changed

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed 7-segment driver. It scans the latched digit
// bytes onto a shared segment bus, one digit per slot, with a blanking gap at
// the start of every slot. A slow blink phase can blank selected digits.
//
// Slot state is decoded from the prescaler, not held in a separate register:
//   state | meaning
//   BLANK | prescaler < BLANK_CYCLES, all commons off, seg_out = 0
//   DRIVE | remainder of the slot, common[index] on, seg_out = digit byte
module seg_scan_mux #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 64,
  parameter int COM_ACT_LOW  = 1
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic [8*NUM_DIGITS-1:0] seg_bus,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   seg_com,
  output logic                    frame_tick
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES);
  localparam logic [NUM_DIGITS-1:0] COM_IDLE =
    (COM_ACT_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [8*NUM_DIGITS-1:0] shadow;
  logic [FW-1:0]           frame_cnt;
  logic                    blink_ph;

  logic                    frame_start;
  logic [8*NUM_DIGITS-1:0] shadow_eff;
  logic                    phase_eff;
  logic                    blanked;
  logic [7:0]              cur_byte;
  logic                    cur_mask;
  logic [NUM_DIGITS-1:0]   com_onehot;
  logic [7:0]              seg_nx;
  logic [NUM_DIGITS-1:0]   com_nx;

  // Decode the slot the current counter position belongs to. At frame start
  // the freshly latched bus and the freshly toggled blink phase are used so the
  // first cycle of a frame already shows new data when there is no blank gap.
  always_comb begin
    frame_start = (presc == '0) && (idx == '0);
    shadow_eff  = frame_start ? seg_bus : shadow;
    phase_eff   = (frame_start && (frame_cnt == FRAME_LAST)) ? ~blink_ph : blink_ph;
    blanked     = int'(presc) < BLANK_CYCLES;
    cur_byte    = 8'h00;
    cur_mask    = 1'b0;
    com_onehot  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_byte      = shadow_eff[8*i +: 8];
        cur_mask      = blink_mask[i];
        com_onehot[i] = 1'b1;
      end
    end
    if (blanked) begin
      seg_nx = 8'h00;
      com_nx = COM_IDLE;
    end else begin
      seg_nx = (cur_mask && phase_eff) ? 8'h00 : cur_byte;
      com_nx = (COM_ACT_LOW != 0) ? ~com_onehot : com_onehot;
    end
  end

  // Scan position: prescaler within a slot, digit index across slots.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PRESC_LAST) begin
      presc <= '0;
      idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Frame-coherent snapshot of the segment bytes and the blink timebase.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      shadow    <= '0;
      frame_cnt <= '0;
      blink_ph  <= 1'b0;
    end else if (frame_start) begin
      shadow <= seg_bus;
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= FW'(1);
        blink_ph  <= ~blink_ph;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Registered display outputs for the slot position decoded this cycle.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      seg_out    <= 8'h00;
      seg_com    <= COM_IDLE;
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= seg_nx;
      seg_com    <= com_nx;
      frame_tick <= frame_start;
    end
  end

endmodule
